// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO slave: register word addresses and reset values.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_BLINK_EN   = 3'd3;
  localparam logic [2:0] ADDR_BLINK_HALF = 3'd4;
  localparam logic [2:0] ADDR_DUTY       = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;
  localparam logic [2:0] ADDR_RSVD       = 3'd7;

  localparam logic [31:0] DATA_RST = 32'd0;

  // DUTY resets to 2^pwm_bits so the LEDs come up at full brightness.
  function automatic logic [16:0] duty_rst(input int pwm_bits);
    duty_rst = 17'd1 << pwm_bits;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Half-period blink timer: phase toggles every half+1 cycles; load restarts it in the on phase.
module led_blink_timer
  import led_pio_pkg::*;
#(
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLINK_W-1:0] half,
  input  logic               load,
  output logic               phase
);

  localparam logic [BLINK_W-1:0] CNT_ONE = BLINK_W'(1);

  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (load) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == half) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_pio_ctrl.sv
// Memory-mapped LED port with atomic set/clear, per-bit blinking and global PWM dimming.
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int BLINK_W  = 24,
  parameter int PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [16:0]         DUTY_RST_FULL = duty_rst(PWM_BITS);
  localparam logic [PWM_BITS:0]   DUTY_RST      = DUTY_RST_FULL[PWM_BITS:0];
  localparam logic [PWM_BITS-1:0] PWM_ONE       = PWM_BITS'(1);

  logic                wr_en;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    blink_en_q;
  logic [BLINK_W-1:0]  blink_half_q;
  logic [PWM_BITS:0]   duty_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic                half_load;
  logic                pwm_on_p0;
  logic [WIDTH-1:0]    led_p0;
  logic [WIDTH-1:0]    led_p1;
  logic [31:0]         rdata;

  assign wr_en     = chipselect && !write_n;
  assign half_load = wr_en && (address == ADDR_BLINK_HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= DATA_RST[WIDTH-1:0];
      blink_en_q   <= '0;
      blink_half_q <= '1;
      duty_q       <= DUTY_RST;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:       data_q       <= writedata[WIDTH-1:0];
        ADDR_SET:        data_q       <= data_q | writedata[WIDTH-1:0];
        ADDR_CLEAR:      data_q       <= data_q & ~writedata[WIDTH-1:0];
        ADDR_BLINK_EN:   blink_en_q   <= writedata[WIDTH-1:0];
        ADDR_BLINK_HALF: blink_half_q <= writedata[BLINK_W-1:0];
        ADDR_DUTY:       duty_q       <= writedata[PWM_BITS:0];
        default:         ;
      endcase
    end
  end

  led_blink_timer #(
    .BLINK_W (BLINK_W)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .half    (blink_half_q),
    .load    (half_load),
    .phase   (phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_ONE;
  end

  // Stage p0: combine DATA, blink gating and PWM gating
  assign pwm_on_p0 = ({1'b0, pwm_cnt} < duty_q);
  assign led_p0    = data_q & (~blink_en_q | {WIDTH{phase}}) & {WIDTH{pwm_on_p0}};

  // Stage p1: registered pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_p1 <= '0;
    else          led_p1 <= led_p0;
  end

  assign out_port = led_p1;

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: rdata[WIDTH-1:0]   = data_q;
      ADDR_BLINK_EN:                   rdata[WIDTH-1:0]   = blink_en_q;
      ADDR_BLINK_HALF:                 rdata[BLINK_W-1:0] = blink_half_q;
      ADDR_DUTY:                       rdata[PWM_BITS:0]  = duty_q;
      ADDR_STATUS:                     rdata[0]           = phase;
      default:                         ;
    endcase
  end

  assign readdata = rdata;

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Directed bench for led_pio_ctrl: register vector table plus blink, PWM and reset sequences.
module tb_led_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int nvec = 0;
  int nbad = 0;

  led_pio_ctrl #(.WIDTH(10), .BLINK_W(24), .PWM_BITS(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        chk_out;
    logic [9:0]  exp_out;
  } vec_t;

  vec_t vecs[26];
  int   nv = 0;

  task automatic addv(input logic wr, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] erd, input logic co, input logic [9:0] eo);
    vecs[nv] = '{wr, a, d, erd, co, eo};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      chipselect = 1'b1;
      write_n    = ~vecs[i].wr;
      #1;
      if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      if (vecs[i].chk_out) chk($sformatf("vec%0d_out", i), {22'd0, out_port}, {22'd0, vecs[i].exp_out});
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int          hi;
    int          shape_bad;
    logic [9:0]  acc;
    logic        e0;
    logic        ephase;

    // Reset-value reads (indices 0..7 are reused after the mid-run reset)
    addv(0, 3'd0, 0, 32'h0,        1, 10'h0);
    addv(0, 3'd1, 0, 32'h0,        1, 10'h0);
    addv(0, 3'd2, 0, 32'h0,        1, 10'h0);
    addv(0, 3'd3, 0, 32'h0,        1, 10'h0);
    addv(0, 3'd4, 0, 32'h00FFFFFF, 1, 10'h0);
    addv(0, 3'd5, 0, 32'h100,      1, 10'h0);
    addv(0, 3'd6, 0, 32'h1,        1, 10'h0);
    addv(0, 3'd7, 0, 32'h0,        1, 10'h0);
    // DATA / SET / CLEAR and one-cycle output latency
    addv(1, 3'd0, 32'hFFFFFFFF, 0, 0, 10'h0);
    addv(0, 3'd0, 0, 32'h3FF,      1, 10'h000);
    addv(0, 3'd1, 0, 32'h3FF,      1, 10'h3FF);
    addv(1, 3'd1, 32'h0,   0, 0, 10'h0);
    addv(1, 3'd2, 32'h00F, 0, 0, 10'h0);
    addv(1, 3'd1, 32'h001, 0, 0, 10'h0);
    addv(0, 3'd0, 0, 32'h3F1,      1, 10'h3F0);
    addv(0, 3'd2, 0, 32'h3F1,      1, 10'h3F1);
    // Other registers, masking of unused bits, ignored writes
    addv(1, 3'd3, 32'hFFFFFC01, 0, 0, 10'h0);
    addv(0, 3'd3, 0, 32'h001,      1, 10'h3F1);
    addv(1, 3'd6, 32'h0,        0, 0, 10'h0);
    addv(1, 3'd7, 32'h1234,     0, 0, 10'h0);
    addv(0, 3'd6, 0, 32'h1,        0, 10'h0);
    addv(0, 3'd7, 0, 32'h0,        0, 10'h0);
    addv(1, 3'd5, 32'hFFFFFFFF, 0, 0, 10'h0);
    addv(0, 3'd5, 0, 32'h1FF,      1, 10'h3F1);
    addv(1, 3'd4, 32'hFFFFFFFF, 0, 0, 10'h0);
    addv(0, 3'd4, 0, 32'h00FFFFFF, 1, 10'h3F1);

    repeat (3) @(negedge clk);
    chk("out_in_reset", {22'd0, out_port}, 32'd0);
    reset_n = 1'b1;

    run_vecs(0, nv - 1);

    // Blink: H=3, bit0 blinks 4 on / 4 off starting on, bit1 steady
    wr(3'd5, 32'h100);
    wr(3'd0, 32'h003);
    wr(3'd3, 32'h001);
    wr(3'd4, 32'd3);
    address = 3'd6;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      e0     = ((k / 4) % 2) == 0;
      ephase = (((k + 1) / 4) % 2) == 0;
      chk($sformatf("blink_out_k%0d", k), {22'd0, out_port}, {30'd0, 1'b1, e0});
      chk($sformatf("blink_status_k%0d", k), readdata, {31'd0, ephase});
    end

    // Rewrite BLINK_HALF while in the off half: phase forced on, then toggles after 6 cycles
    repeat (5) @(negedge clk);
    wr(3'd4, 32'd5);
    address = 3'd6;
    #1;
    chk("rehalf_j0", readdata, 32'd1);
    for (int j = 1; j < 14; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rehalf_j%0d", j), readdata, {31'd0, ((j / 6) % 2) == 0});
    end

    // PWM: DUTY=64 gives 64 high cycles in every 256
    wr(3'd3, 32'h0);
    wr(3'd0, 32'h3FF);
    wr(3'd5, 32'd64);
    repeat (3) @(negedge clk);
    hi = 0;
    shape_bad = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (out_port == 10'h3FF) hi++;
      else if (out_port != 10'h0) shape_bad++;
    end
    chk("pwm64_high_cycles", hi, 64);
    chk("pwm64_partial_words", shape_bad, 0);

    wr(3'd5, 32'd0);
    repeat (2) @(negedge clk);
    acc = '0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      acc = acc | out_port;
    end
    chk("pwm_duty0_or", {22'd0, acc}, 32'd0);

    wr(3'd5, 32'h1FF);
    repeat (2) @(negedge clk);
    acc = '1;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      acc = acc & out_port;
    end
    chk("pwm_duty1ff_and", {22'd0, acc}, 32'h3FF);

    // Asynchronous reset in the middle of blinking
    wr(3'd5, 32'h100);
    wr(3'd0, 32'h155);
    wr(3'd3, 32'h001);
    wr(3'd4, 32'd3);
    repeat (3) @(negedge clk);
    chk("preset_out_hi", {23'd0, out_port[9:1]}, 32'h0AA);
    address = 3'd0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", {22'd0, out_port}, 32'd0);
    chk("async_rst_data", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vecs(0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
